clock_gate_ctrl: RTL
====================

Name: clock_gate_ctrl

Overview:
- Sequences the CE input of a gated global clock buffer (BUFGCE_1) so that a downstream clock domain runs only while at least one requester needs it.
- Merges NREQ clock requests and a software force bit.
- Applies a fixed wake-up settle period before granting, and an idle hysteresis period before gating off.
- Counts wake events for power profiling; sits in the always-on clk domain beside the buffer.

Parameters:
- NREQ, 4, number of requesters (1..8).
- WAKE_CYCLES, 2, cycles CE is held high before any ack is given (1..255).
- IDLE_CYCLES, 16, cycles without requests before CE drops (1..255).
- CNT_W, 8, width of wake event counter.

Ports:
- clk  input  1  always-running controller clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester clock request, level-sensitive.
- force_on  input  1  software override; acts as a request but never acked.
- ce  output  1  registered clock enable to buffer CE pin.
- ack  output  NREQ  per-requester grant: gated clock is running and stable.
- state  output  2  current state: 0=OFF, 1=WAKE, 2=ON, 3=IDLE.
- wake_count  output  CNT_W  number of OFF->WAKE transitions, saturating.

Behaviour:
- Reset is synchronous and active-high on clk. On reset: state=OFF, ce=0, ack=0, wake_count=0, internal counter=0.
- Reset asserted in any state forces OFF at the next edge. ce drops with no hysteresis.
- Define any_req = |req | force_on.
- All outputs are registered. No combinational path exists from inputs to outputs.

State machine:
- OFF (ce=0, ack=0):
  - any_req=1 -> WAKE; load counter=WAKE_CYCLES-1; ce=1 from the next cycle.
  - wake_count increments on this transition and saturates at 2^CNT_W-1.
- WAKE (ce=1, ack=0):
  - Lasts exactly WAKE_CYCLES cycles; counter decrements each cycle.
  - At counter=0 -> ON, regardless of any_req. WAKE is not abortable.
- ON (ce=1):
  - Register ack[i] <= req[i] while the next state is ON.
  - any_req=0 -> IDLE; load counter=IDLE_CYCLES-1; ack clears at the same edge.
- IDLE (ce=1, ack=0):
  - any_req=1 -> ON at the next edge; acks for requesting bits are high in that first ON cycle.
  - Otherwise counter decrements; at counter=0 with any_req=0 -> OFF; ce=0 from the next cycle.
  - With any_req=1 at counter=0, the request wins and the next state is ON.

Timing:
- OFF, req[i] rises in cycle t:
  - ce=1 in cycle t+1.
  - WAKE occupies t+1..t+WAKE_CYCLES.
  - ON and ack[i]=1 in cycle t+WAKE_CYCLES+1.
- ON, req[i] falls in cycle t: ack[i]=0 in cycle t+1. Other acks are unaffected.
- Last request drops in cycle t during ON:
  - IDLE occupies t+1..t+IDLE_CYCLES.
  - ce=0 in cycle t+IDLE_CYCLES+1.

Constraints and edge cases:
- ce toggles only on clk rising edges and never glitches. It changes only on OFF->WAKE and IDLE->OFF.
- force_on alone: the FSM reaches ON and stays there with ack=0 for all bits.
- force_on in combination with requests: acks follow req normally.
- Simultaneous rise and fall of different req bits in ON: each ack bit tracks its own req. The FSM stays in ON if any bit remains high.
- The counter never underflows. Loads occur only on entry to WAKE or IDLE.

Test Plan:
- Reset, then req=4'b0001 at cycle 10, WAKE_CYCLES=2:
  - ce=1 at 11, state=WAKE at 11..12.
  - ack=4'b0001 and state=ON at 13.
  - wake_count=1.
- In ON, drop req at cycle 20, IDLE_CYCLES=16:
  - ack=0 and state=IDLE at 21.
  - state=IDLE through 36, ce=0 and state=OFF at 37.
- Re-request req=4'b0100 during IDLE at cycle 30:
  - state=ON and ack=4'b0100 at 31.
  - ce never drops; wake_count unchanged.
- force_on=1 alone:
  - Reaches ON with ack=0.
  - req=4'b1010 in ON gives ack=4'b1010 one cycle later.
  - Clear req with force_on still high: FSM stays in ON.
- Assert reset for one cycle while in ON with ack=4'b1111:
  - Next cycle state=OFF, ce=0, ack=0, wake_count=0.
- Drive 300 OFF->WAKE cycles with CNT_W=8:
  - wake_count saturates at 255.
  - ce only ever changes at OFF->WAKE and IDLE->OFF edges; checked by assertion.

Source files
------------

// File: rtl/clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clock_gate_ctrl
//
// Purpose:
//   Drives the CE pin of a gated global clock buffer (BUFGCE_1) so that a
//   downstream clock domain only runs while somebody needs it. Requests from
//   NREQ clients and a software force bit are merged. A fixed wake-up settle
//   period elapses before any client is told the clock is good, and an idle
//   hysteresis period elapses before the clock is switched off again. Wake
//   events are counted (saturating) for power profiling. Lives in the
//   always-on clk domain next to the buffer.
//
// Ports:
//   clk        in   1      always-running controller clock
//   reset      in   1      synchronous, active-high reset
//   req        in   NREQ   per-requester clock request (level)
//   force_on   in   1      software override, behaves as a request, never acked
//   ce         out  1      registered clock enable for the buffer CE pin
//   ack        out  NREQ   per-requester grant: gated clock running and stable
//   state      out  2      0=OFF, 1=WAKE, 2=ON, 3=IDLE
//   wake_count out  CNT_W  number of OFF->WAKE transitions, saturating
// ---------------------------------------------------------------------------
module clock_gate_ctrl #(
  parameter int NREQ        = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             force_on,
  output logic             ce,
  output logic [NREQ-1:0]  ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] wake_count
);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StWake = 2'd1,
    StOn   = 2'd2,
    StIdle = 2'd3
  } state_e;

  // Both settle periods fit in 8 bits; the counter is loaded with the
  // period minus one so that it reads zero in the last cycle of the period.
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [CNT_W-1:0] wakeCnt_q, wakeCnt_d;
  logic             anyReq;

  // Next-state logic. The software force bit counts as a request for
  // sequencing purposes but is never reflected on ack. WAKE cannot be
  // aborted, and in IDLE a fresh request always beats the timeout, even in
  // the very last idle cycle.
  always_comb begin
    anyReq    = (|req) | force_on;
    state_d   = state_q;
    cnt_d     = cnt_q;
    wakeCnt_d = wakeCnt_q;

    case (state_q)
      StOff: begin
        if (anyReq) begin
          state_d = StWake;
          cnt_d   = WAKE_LOAD;
          if (wakeCnt_q != '1) begin
            wakeCnt_d = wakeCnt_q + 1'b1;
          end
        end
      end

      StWake: begin
        if (cnt_q == 8'd0) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StOn: begin
        if (!anyReq) begin
          state_d = StIdle;
          cnt_d   = IDLE_LOAD;
        end
      end

      StIdle: begin
        if (anyReq) begin
          state_d = StOn;
        end else if (cnt_q == 8'd0) begin
          state_d = StOff;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StOff;
      end
    endcase

    // Acks mirror the requests only while we will be in ON next cycle, so
    // the first ON cycle already shows the grants and leaving ON clears them
    // at the same edge. ce is derived from the next state so the buffer
    // enable only moves on OFF->WAKE and IDLE->OFF (or reset).
    ack_d = (state_d == StOn) ? req : '0;
    ce_d  = (state_d != StOff);
  end

  // State and output registers; every output comes straight from a flop so
  // the buffer CE pin never sees a combinational glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StOff;
      cnt_q     <= 8'd0;
      ce_q      <= 1'b0;
      ack_q     <= '0;
      wakeCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      ack_q     <= ack_d;
      wakeCnt_q <= wakeCnt_d;
    end
  end

  assign ce         = ce_q;
  assign ack        = ack_q;
  assign state      = state_q;
  assign wake_count = wakeCnt_q;

endmodule
